// File: rtl/uart_tx_async.sv
// UART transmitter: serialises one queued byte per frame (start, 7/8 data LSB-first, optional parity, stop)
// at 16 baud_clock strobes per bit, with a one-entry holding register fed by writes or an external FIFO.
module uart_tx_async #(
    parameter int TX_FIFO = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_clock,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       write_tx_byte,
    input  logic [7:0] tx_data,
    input  logic       fifo_empty,
    output logic       fifo_read_en,
    output logic       tx,
    output logic       tx_hold_empty,
    output logic       tx_idle,
    output logic       tx_done
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t     state_q, state_d;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       parity_q, parity_d;
    logic       cfg_bit8_q, cfg_bit8_d;
    logic       cfg_par_en_q, cfg_par_en_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_empty_d;
    logic       pend_q;
    logic       read_en_d;
    logic       tx_d;
    logic       done_d;
    logic       load;
    logic       capture;
    logic [2:0] last_bit;

    assign last_bit = cfg_bit8_q ? 3'd7 : 3'd6;
    assign tx_idle  = (state_q == IDLE);

    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        cfg_bit8_d   = cfg_bit8_q;
        cfg_par_en_d = cfg_par_en_q;
        load         = 1'b0;
        done_d       = 1'b0;

        if (baud_clock) begin
            tick_d = tick_q + 4'd1;
            case (state_q)
                IDLE: begin
                    tick_d = '0;
                    load   = !tx_hold_empty;
                end
                START: begin
                    if (tick_q == 4'd15) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    if (tick_q == 4'd15) begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        parity_d  = parity_q ^ shift_q[0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == last_bit)
                            state_d = cfg_par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (tick_q == 4'd15)
                        state_d = STOP;
                end
                STOP: begin
                    if (tick_q == 4'd15) begin
                        done_d = 1'b1;
                        if (tx_hold_empty)
                            state_d = IDLE;
                        else
                            load = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            // Frame configuration is frozen here so mid-frame changes only affect the next frame.
            if (load) begin
                state_d      = START;
                tick_d       = '0;
                shift_d      = hold_q;
                parity_d     = odd_n_even;
                cfg_bit8_d   = bit8;
                cfg_par_en_d = parity_en;
            end
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
    end

    // Holding register: written directly, or refilled from the FIFO one clk after the pop.
    always_comb begin
        hold_d       = hold_q;
        hold_empty_d = tx_hold_empty;
        capture      = (TX_FIFO != 0) ? pend_q : (write_tx_byte && tx_hold_empty);
        if (capture) begin
            hold_d       = tx_data;
            hold_empty_d = 1'b0;
        end
        if (load)
            hold_empty_d = 1'b1;
        read_en_d = (TX_FIFO != 0) && tx_hold_empty && !fifo_empty && !fifo_read_en && !pend_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            tick_q        <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            cfg_bit8_q    <= 1'b0;
            cfg_par_en_q  <= 1'b0;
            hold_q        <= '0;
            tx_hold_empty <= 1'b1;
            pend_q        <= 1'b0;
            fifo_read_en  <= 1'b0;
            tx            <= 1'b1;
            tx_done       <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_q        <= tick_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            cfg_bit8_q    <= cfg_bit8_d;
            cfg_par_en_q  <= cfg_par_en_d;
            hold_q        <= hold_d;
            tx_hold_empty <= hold_empty_d;
            pend_q        <= fifo_read_en;
            fifo_read_en  <= read_en_d;
            tx            <= tx_d;
            tx_done       <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_async.sv
// Scoreboard bench for uart_tx_async: a register-fed instance and a FIFO-fed instance, each with a
// line monitor that decodes frames from tx and compares them with hand-computed expected bit strings.
module tb_uart_tx_async;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, baud_clock, bit8, parity_en, odd_n_even, write_tx_byte;
    logic [7:0] tx_data;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_go;
    logic       fifo_empty;
    logic       rd_en0, tx0, hold_empty0, idle0, done0;
    logic       rd_en1, tx1, hold_empty1, idle1, done1;

    int         rd_ptr = 0;
    int         pops = 0;
    int         bad_pops = 0;
    logic [7:0] fifo_mem [2] = '{8'h11, 8'h22};

    assign fifo_empty = !fifo_go || (rd_ptr >= 2);

    uart_tx_async #(.TX_FIFO(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .bit8(bit8),
        .parity_en(parity_en), .odd_n_even(odd_n_even), .write_tx_byte(write_tx_byte),
        .tx_data(tx_data), .fifo_empty(fifo_empty), .fifo_read_en(rd_en0), .tx(tx0),
        .tx_hold_empty(hold_empty0), .tx_idle(idle0), .tx_done(done0)
    );

    uart_tx_async #(.TX_FIFO(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .bit8(bit8),
        .parity_en(parity_en), .odd_n_even(odd_n_even), .write_tx_byte(write_tx_byte),
        .tx_data(fifo_dout), .fifo_empty(fifo_empty), .fifo_read_en(rd_en1), .tx(tx1),
        .tx_hold_empty(hold_empty1), .tx_idle(idle1), .tx_done(done1)
    );

    // External FIFO model: data appears on fifo_dout the clk after a pop.
    always @(posedge clk) begin
        if (rd_en1) begin
            if (rd_ptr >= 2)
                bad_pops <= bad_pops + 1;
            else
                fifo_dout <= fifo_mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end
        if (rd_en0)
            bad_pops <= bad_pops + 1;
    end

    // 16x baud strobe: one clk high every four clks.
    initial begin
        baud_clock = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            baud_clock = 1'b1;
            @(negedge clk);
            baud_clock = 1'b0;
        end
    end

    typedef struct {
        string bits;
        bit    b2b;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   frames_done[2] = '{0, 0};
    int   done_cnt[2] = '{0, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] str2bits(input string s);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < s.len(); i++)
            if (s[i] == "1") v[i] = 1'b1;
        return v;
    endfunction

    // Decodes frames mid-bit; bit k of a frame is sampled 16*k+8 strobes after the start edge.
    task automatic run_monitor(input int which);
        bit          in_frame = 0;
        bit          ended;
        bit          gap0 = 0;
        int          s = 0;
        int          n = 10;
        logic [31:0] got = '0;
        exp_t        e;
        logic        txv, dv;
        forever begin
            @(posedge clk);
            #1;
            txv = (which == 0) ? tx0 : tx1;
            dv  = (which == 0) ? done0 : done1;
            if (dv) done_cnt[which]++;
            ended = 0;
            if (!reset_n) begin
                in_frame = 0;
            end else if (baud_clock) begin
                if (in_frame) begin
                    s++;
                    if (s % 16 == 8) got[s / 16] = txv;
                    if (s == 16 * n) begin
                        check($sformatf("m%0d_frame_%s", which, e.bits), got, str2bits(e.bits));
                        check($sformatf("m%0d_done_%s", which, e.bits), {31'b0, dv}, 1);
                        check($sformatf("m%0d_b2b_%s", which, e.bits), {31'b0, gap0}, {31'b0, e.b2b});
                        frames_done[which]++;
                        in_frame = 0;
                        ended = 1;
                    end
                end
                if (!in_frame && txv == 1'b0) begin
                    gap0     = ended;
                    in_frame = 1;
                    s        = 0;
                    got      = '0;
                    if (which == 0 && exp_q0.size() > 0)
                        e = exp_q0.pop_front();
                    else if (which == 1 && exp_q1.size() > 0)
                        e = exp_q1.pop_front();
                    else begin
                        e.bits = "1111111111";
                        e.b2b  = 0;
                    end
                    n = e.bits.len();
                end
            end
        end
    endtask

    task automatic write_byte(input logic [7:0] v);
        @(negedge clk);
        tx_data = v;
        write_tx_byte = 1'b1;
        @(negedge clk);
        write_tx_byte = 1'b0;
    endtask

    task automatic wait_start0(input string name);
        int t = 0;
        while (tx0 !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_start"}, {31'b0, tx0}, 0);
    endtask

    task automatic wait_frames(input int which, input int want, input string name);
        int t = 0;
        while (!(frames_done[which] == want && ((which == 0) ? idle0 : idle1)) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_frames"}, frames_done[which], want);
        check({name, "_idle"}, {31'b0, (which == 0) ? idle0 : idle1}, 1);
    endtask

    initial begin
        int t;
        int dcnt;
        reset_n = 1'b0;
        bit8 = 1'b1;
        parity_en = 1'b0;
        odd_n_even = 1'b0;
        write_tx_byte = 1'b0;
        tx_data = 8'h00;
        fifo_go = 1'b0;
        fork
            run_monitor(0);
            run_monitor(1);
        join_none

        repeat (4) @(negedge clk);
        check("rst_tx0", {31'b0, tx0}, 1);
        check("rst_hold0", {31'b0, hold_empty0}, 1);
        check("rst_idle0", {31'b0, idle0}, 1);
        check("rst_done0", {31'b0, done0}, 0);
        check("rst_rd_en1", {31'b0, rd_en1}, 0);
        check("rst_tx1", {31'b0, tx1}, 1);
        reset_n = 1'b1;

        // 8N1 0xA5
        exp_q0.push_back('{"0101001011", 1'b0});
        write_byte(8'hA5);
        wait_start0("8n1");
        check("8n1_hold_empty_at_load", {31'b0, hold_empty0}, 1);
        wait_frames(0, 1, "8n1");

        // 7E1 0x83: bit 7 neither sent nor counted in parity
        @(negedge clk);
        bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b0;
        exp_q0.push_back('{"0110000001", 1'b0});
        write_byte(8'h83);
        wait_frames(0, 2, "7e1");

        // 8O1 0x00 with config toggled mid-frame
        @(negedge clk);
        bit8 = 1'b1; parity_en = 1'b1; odd_n_even = 1'b1;
        exp_q0.push_back('{"00000000011", 1'b0});
        write_byte(8'h00);
        wait_start0("8o1");
        repeat (200) @(negedge clk);
        odd_n_even = 1'b0; bit8 = 1'b0; parity_en = 1'b0;
        wait_frames(0, 3, "8o1");

        // Back-to-back 0x55, 0x0F; a third write while full is dropped
        @(negedge clk);
        bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
        exp_q0.push_back('{"0101010101", 1'b0});
        exp_q0.push_back('{"0111100001", 1'b1});
        write_byte(8'h55);
        t = 0;
        while (hold_empty0 !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("b2b_first_loaded", {31'b0, hold_empty0}, 1);
        write_byte(8'h0F);
        check("b2b_hold_full", {31'b0, hold_empty0}, 0);
        write_byte(8'hEE);
        wait_frames(0, 5, "b2b");

        // Reset mid-frame during DATA of 0xFF with a second byte queued
        write_byte(8'hFF);
        wait_start0("rst_mid");
        write_byte(8'h3C);
        repeat (200) @(negedge clk);
        dcnt = done_cnt[0];
        reset_n = 1'b0;
        #1;
        check("rst_mid_tx", {31'b0, tx0}, 1);
        check("rst_mid_hold_empty", {31'b0, hold_empty0}, 1);
        check("rst_mid_idle", {31'b0, idle0}, 1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (300) @(negedge clk);
        check("rst_mid_still_idle", {31'b0, idle0}, 1);
        check("rst_mid_no_done", done_cnt[0], dcnt);
        check("rst_mid_no_frame", frames_done[0], 5);

        // FIFO-fed instance drains 0x11, 0x22
        exp_q1.push_back('{"0100010001", 1'b0});
        exp_q1.push_back('{"0010001001", 1'b1});
        @(negedge clk);
        fifo_go = 1'b1;
        wait_frames(1, 2, "fifo");
        check("fifo_pops", pops, 2);
        check("fifo_bad_pops", bad_pops, 0);
        check("fifo_hold_empty", {31'b0, hold_empty1}, 1);
        check("fifo_done_cnt", done_cnt[1], 2);
        check("reg_done_cnt", done_cnt[0], 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
